// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered
// coprocessor results. A starvation guard forces the FIFO head out after a bounded wait.
module core_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_DEPTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          cp_valid,
  output logic                          cp_ready,
  input  logic [REG_ADDR_WIDTH-1:0]     cp_rd,
  input  logic [DATA_WIDTH-1:0]         cp_data,
  output logic                          rf_we,
  output logic [REG_ADDR_WIDTH-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [REG_DEPTH-1:0]          pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  // Handshake rule for both sources: a transfer happens at a rising edge
  // where valid && ready; ready never depends on the same-cycle valid.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_CP   = 2'd2
  } grant_e;

  logic [REG_ADDR_WIDTH-1:0] mem_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     slot_vld;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [AGE_W-1:0]          age;
  logic                      fifo_empty;
  logic                      starve;
  logic                      push;
  logic                      pop;
  grant_e                    grant;

  assign fifo_empty = (count == '0);
  assign cp_ready   = (count < CNT_W'(FIFO_DEPTH));
  assign starve     = (age == AGE_W'(STARVE_LIMIT)) && !fifo_empty;
  assign wb_ready   = !starve;
  // x0 results complete the handshake but are dropped here.
  assign push       = cp_valid && cp_ready && (cp_rd != '0);
  assign pop        = (grant == GNT_CP);
  assign fifo_count = count;

  always_comb begin
    grant = GNT_NONE;
    if (starve) begin
      grant = GNT_CP;
    end else if (wb_valid && (wb_rd != '0)) begin
      grant = GNT_WB;
    end else if (!fifo_empty) begin
      grant = GNT_CP;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld[i]) begin
        pending_mask[mem_rd[i]] = 1'b1;
      end
    end
  end

  // Storage needs no reset: slot_vld qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= cp_rd;
      mem_data[wr_ptr] <= cp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      age      <= '0;
    end else begin
      if (pop) begin
        slot_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      // Push only happens when not full, so wr_ptr never equals a popping rd_ptr.
      if (push) begin
        slot_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo_empty || pop) begin
        age <= '0;
      end else if (age != AGE_W'(STARVE_LIMIT)) begin
        age <= age + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (grant)
        GNT_WB: begin
          rf_we    <= 1'b1;
          rf_waddr <= wb_rd;
          rf_wdata <= wb_data;
        end
        GNT_CP: begin
          rf_we    <= 1'b1;
          rf_waddr <= mem_rd[rd_ptr];
          rf_wdata <= mem_data[rd_ptr];
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Bench for core_wb_arbiter: directed scenarios then random traffic, all
// checked against a queue-based model of the arbitration rules.
module tb_core_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREG  = 32;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            cp_valid;
  logic            cp_ready;
  logic [AW-1:0]   cp_rd;
  logic [DW-1:0]   cp_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] pending_mask;
  logic [1:0]      fifo_count;

  core_wb_arbiter #(
    .DATA_WIDTH(DW), .REG_DEPTH(NREG), .REG_ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_rd(cp_rd), .cp_data(cp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: queue of buffered results, wait age, expected rf outputs
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            age;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    age      = 0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic model_step(input logic wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                            input logic cv, input logic [AW-1:0] crd, input logic [DW-1:0] cd,
                            output logic wacc, output logic cacc);
    bit   st;
    bit   was_empty;
    bit   popped;
    ent_t e;
    was_empty = (q.size() == 0);
    st        = (age == LIM) && !was_empty;
    popped    = 0;
    wacc      = wv && !st;
    cacc      = cv && (q.size() < DEPTH);
    if (st || (!(wv && wrd != 0) && !was_empty)) begin
      e        = q.pop_front();
      exp_we   = 1'b1;
      exp_addr = e.rd;
      exp_data = e.d;
      popped   = 1;
    end else if (wv && wrd != 0) begin
      exp_we   = 1'b1;
      exp_addr = wrd;
      exp_data = wd;
    end else begin
      exp_we = 1'b0;
    end
    if (was_empty || popped) age = 0;
    else if (age < LIM) age++;
    if (cacc && crd != 0) begin
      e.rd = crd;
      e.d  = cd;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    logic [NREG-1:0] m;
    m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    chk("rf_we", 64'(rf_we), 64'(exp_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(exp_addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(exp_data));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("pending_mask", 64'(pending_mask), 64'(m));
    chk("cp_ready", 64'(cp_ready), 64'(q.size() < DEPTH));
    chk("wb_ready", 64'(wb_ready), 64'(!((age == LIM) && q.size() != 0)));
  endtask

  // Driver: called at a falling edge; applies inputs, steps model, checks after the edge
  task automatic drive_cycle(input logic wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                             input logic cv, input logic [AW-1:0] crd, input logic [DW-1:0] cd,
                             output logic wacc, output logic cacc);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    cp_valid = cv; cp_rd = crd; cp_data = cd;
    model_step(wv, wrd, wd, cv, crd, cd, wacc, cacc);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    logic wa, ca;
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0, 0, 0, wa, ca);
  endtask

  initial begin
    logic wa, ca;
    int   rd;
    int   stalls;
    logic cpend;
    int   cidx;
    logic          rwv, rcv;
    logic [AW-1:0] rwrd, rcrd;
    logic [DW-1:0] rwd, rcd;

    rst_n = 1'b0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    cp_valid = 0; cp_rd = 0; cp_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single pipeline write, one-cycle latency
    drive_cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, wa, ca);
    chk("wb5_we", 64'(rf_we), 64'd1);
    chk("wb5_addr", 64'(rf_waddr), 64'd5);
    chk("wb5_data", 64'(rf_wdata), 64'hDEADBEEF);
    idle(1);
    chk("wb5_we_drop", 64'(rf_we), 64'd0);

    // Coprocessor push while pipeline idle
    drive_cycle(0, 0, 0, 1, 7, 32'h11, wa, ca);
    chk("cp7_pending", 64'(pending_mask[7]), 64'd1);
    idle(1);
    chk("cp7_addr", 64'(rf_waddr), 64'd7);
    chk("cp7_data", 64'(rf_wdata), 64'h11);
    chk("cp7_pending_clr", 64'(pending_mask[7]), 64'd0);
    idle(1);

    // Continuous pipeline traffic plus one coprocessor result: exactly one starve stall
    rd = 1; cpend = 1; stalls = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1, AW'(rd), 32'h1000 + rd, cpend, 9, 32'h99, wa, ca);
      if (wa) rd++; else stalls++;
      if (ca) cpend = 0;
    end
    chk("starve_stalls", 64'(stalls), 64'd1);
    idle(2);

    // Three back-to-back coprocessor results against a busy pipeline
    rd = 20; cidx = 0;
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1, AW'(rd), 32'h2000 + rd, cidx < 3, AW'(10 + cidx), 32'hA0 + cidx, wa, ca);
      if (wa) rd = (rd == 31) ? 20 : rd + 1;
      if (ca && cidx < 3) cidx++;
      if (k == 1) chk("cp_full_ready", 64'(cp_ready), 64'd0);
    end
    chk("cp_all_accepted", 64'(cidx), 64'd3);
    idle(4);

    // x0 from both sources: handshakes complete, nothing written or queued
    chk("x0_wb_ready", 64'(wb_ready), 64'd1);
    chk("x0_cp_ready", 64'(cp_ready), 64'd1);
    drive_cycle(1, 0, 32'h55, 1, 0, 32'h66, wa, ca);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_count", 64'(fifo_count), 64'd0);

    // Random traffic with hold-while-stalled behaviour on both sources
    rwv = 0; rcv = 0; rwrd = 0; rcrd = 0; rwd = 0; rcd = 0;
    for (int k = 0; k < 400; k++) begin
      if (!rwv) begin
        rwv  = ($urandom_range(0, 99) < 60);
        rwrd = AW'($urandom_range(0, 31));
        rwd  = $urandom;
      end
      if (!rcv) begin
        rcv  = ($urandom_range(0, 99) < 45);
        rcrd = AW'($urandom_range(0, 31));
        rcd  = $urandom;
      end
      drive_cycle(rwv, rwrd, rwd, rcv, rcrd, rcd, wa, ca);
      if (wa) rwv = 0;
      if (ca) rcv = 0;
    end
    idle(6);

    // Asynchronous reset with two buffered entries
    for (int k = 0; k < 6 && q.size() < 2; k++)
      drive_cycle(1, AW'(k + 1), 32'h3000 + k, 1, AW'(k + 14), 32'hC0 + k, wa, ca);
    chk("pre_reset_count", 64'(fifo_count), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_mask", 64'(pending_mask), 64'd0);
    chk("arst_cp_ready", 64'(cp_ready), 64'd1);
    chk("arst_wb_ready", 64'(wb_ready), 64'd1);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
